crate_bus_capture: RTL and testbench
====================================

Name: crate_bus_capture

Overview:
- Front-end stage of the PSS crate interface. It sits directly upstream of the burst-write control logic that packs module, port and data words into the Avalon write master.
- It synchronises the asynchronous crate bus strobe and samples A[9:0]/D[7:0] once per bus write cycle.
- It keeps only writes addressed to this crate's module-valid code, buffers them in a show-ahead FIFO, and offers one record per valid/ready handshake.
- This replaces free-running periodic sampling of the bus with event-driven capture.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on strb_n (minimum 2).
- SETTLE, 4, clk cycles between the synchronised strobe falling edge and the A/D sample (minimum 1).
- FIFO_DEPTH, 8, record entries; must be a power of 2.
- MODULE_ID, 3'b000, required value of A[9:7] for a write to be accepted.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- A, in, 10, crate address bus: [4:0] module select, [6:5] port, [9:7] module-valid code.
- D, in, 8, crate data bus.
- strb_n, in, 1, asynchronous crate write strobe, active low.
- rec_valid, out, 1, FIFO head is valid.
- rec_ready, in, 1, consumer accepts the head this cycle.
- rec_address, out, 5, head A[4:0].
- rec_port, out, 2, head A[6:5].
- rec_data, out, 8, head D.
- fifo_level, out, log2(FIFO_DEPTH)+1, number of stored records.
- overflow, out, 1, sticky flag: a matching write was dropped because the FIFO was full.
- clear_overflow, in, 1, synchronous clear of overflow and drop_count.
- drop_count, out, DROP_W, count of dropped matching writes; saturates at all-ones.
- busy, out, 1, FSM not in IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE and the FIFO empties; any in-flight capture is lost.
  - Outputs: rec_valid=0, rec_address/rec_port/rec_data=0, fifo_level=0, overflow=0, drop_count=0, busy=0.
  - Synchroniser flops reset to 1, so no false strobe edge appears after reset.
- Input registering:
  - strb_n passes through SYNC_STAGES flops.
  - A and D are registered every cycle into a_q/d_q (one stage). The bus protocol guarantees A/D are stable from before strobe fall until after strobe rise.
- Falling-edge detect: synchronised strobe is 0 and its previous value was 1.
- FSM states and transitions:
  - IDLE: on falling edge, go to SETTLE and load settle_cnt=SETTLE-1.
  - SETTLE: decrement settle_cnt. If the synchronised strobe returns high (glitch), go to IDLE with no push. When settle_cnt=0, go to CAPTURE.
  - CAPTURE (one cycle): evaluate a_q[9:7]==MODULE_ID.
    - Match with space: push {a_q[4:0], a_q[6:5], d_q}.
    - Match with FIFO full: drop the record, set overflow=1, increment drop_count (saturating).
    - Mismatch: ignore silently; counters unchanged.
    - Always go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until the synchronised strobe is 1, then go to IDLE. Exactly one capture per strobe low period.
- Latency: rec_valid rises SYNC_STAGES+SETTLE+2 clk edges after the first edge that samples strb_n low (8 with defaults), given an empty FIFO.
- FIFO (show-ahead):
  - rec_* always reflect the head entry; rec_valid = level != 0.
  - Pop occurs when rec_valid && rec_ready. rec_ready while empty is ignored.
  - "Space" means level<FIFO_DEPTH, or level==FIFO_DEPTH with a pop in the same cycle. Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.
  - Record fields carry raw bus levels; polarity inversion is done downstream.
- clear_overflow:
  - Clears overflow and drop_count.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Width rules: drop_count holds at 2^DROP_W-1 once reached; overflow stays 1.

Decomposition:
- Package pss_crate_pkg holds:
  - the record struct crate_rec_t {addr[4:0], port[1:0], data[7:0]};
  - field widths ADDR_W=5, PORT_W=2, DATA_W=8, VALID_W=3;
  - the FSM enum {IDLE, SETTLE, CAPTURE, WAIT_RELEASE}.
- One sub-module, crate_rec_fifo: a parameterised show-ahead FIFO of crate_rec_t with level output and push-when-full-with-pop support.
- The synchroniser, edge detect, FSM and counters stay in the top module.

Test Plan:
- Single write: A=10'b000_10_00101, D=8'hA5, strb_n low for 12 cycles, rec_ready=0. Expect rec_valid on the 8th edge with rec_address=5, rec_port=2, rec_data=A5, fifo_level=1; exactly one record even though strobe is held low.
- Module filter: A[9:7]=3'b101, strobe low for 12 cycles. Expect no push, fifo_level=0, overflow=0, busy returns to 0 after strobe release.
- Glitch: strb_n low for 3 cycles (shorter than SYNC_STAGES+SETTLE). Expect no record, FSM back in IDLE.
- Overflow: 9 matching writes with rec_ready=0. Expect fifo_level=8, overflow=1, drop_count=1; first 8 records intact, read back in order D=0..7.
- Full with pop: FIFO full, rec_ready=1 held during a capture cycle. Expect push accepted, fifo_level stays 8, overflow stays 0; clear_overflow coincident with a drop gives drop_count=1.
- Reset mid-capture: assert reset_n=0 during SETTLE with 3 records stored. Expect all outputs 0 immediately, FIFO empty, and no false capture after release while strb_n is held high.

Source files
------------

// File: rtl/pss_crate_pkg.sv
// Shared types and constants for the PSS crate bus capture front-end.
package pss_crate_pkg;

    localparam int ADDR_W  = 5;
    localparam int PORT_W  = 2;
    localparam int DATA_W  = 8;
    localparam int VALID_W = 3;

    // One captured crate write: module select, port and data, raw bus levels.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PORT_W-1:0] port;
        logic [DATA_W-1:0] data;
    } crate_rec_t;

    // Capture FSM states (prefixed so they never collide with the SETTLE parameter).
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_SETTLE       = 2'd1,
        ST_CAPTURE      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } crate_state_e;

    // Split a registered address/data pair into a record.
    function automatic crate_rec_t pack_rec(input logic [9:0] a, input logic [7:0] d);
        crate_rec_t r;
        r.addr = a[4:0];
        r.port = a[6:5];
        r.data = d;
        return r;
    endfunction

endpackage

// File: rtl/crate_rec_fifo.sv
// Show-ahead FIFO of crate records. The head is always visible; a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module crate_rec_fifo
    import pss_crate_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  crate_rec_t       push_rec,
    input  logic             ready,
    output logic             space,
    output crate_rec_t       head,
    output logic             valid,
    output logic [LVL_W-1:0] level
);

    crate_rec_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt;
    logic             valid_r;
    logic             pop_s;
    logic             wr_s;

    assign pop_s = (level_r != {LVL_W{1'b0}}) && ready;
    assign space = (level_r != LVL_W'(DEPTH)) || pop_s;
    assign wr_s  = push && space;

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        level_nxt = level_r;
        case ({wr_s, pop_s})
            2'b10:   level_nxt = level_r + LVL_W'(1);
            2'b01:   level_nxt = level_r - LVL_W'(1);
            default: level_nxt = level_r;
        endcase
    end

    // Storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_s) begin
            mem_r[wr_ptr_r] <= push_rec;
        end
    end

    // Pointers (wrap naturally at a power-of-two depth), level and valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt;
            valid_r <= (level_nxt != {LVL_W{1'b0}});
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign valid = valid_r;
    assign level = level_r;

endmodule

// File: rtl/crate_bus_capture.sv
// Crate bus front-end: synchronises the write strobe, samples A/D once per
// bus write after a settle delay, filters on the module-valid code and
// queues matching writes for the burst-write logic.
module crate_bus_capture
    import pss_crate_pkg::*;
#(
    parameter  int         SYNC_STAGES = 2,
    parameter  int         SETTLE      = 4,
    parameter  int         FIFO_DEPTH  = 8,
    parameter  logic [2:0] MODULE_ID   = 3'b000,
    parameter  int         DROP_W      = 8,
    localparam int         LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        A,
    input  logic [7:0]        D,
    input  logic              strb_n,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [4:0]        rec_address,
    output logic [1:0]        rec_port,
    output logic [7:0]        rec_data,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    input  logic              clear_overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    logic [1:0]             rst_sync_r;
    logic                   rst_n_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   strb_s;
    logic                   strb_prev_r;
    logic                   fall_s;
    logic [9:0]             a_q_r;
    logic [7:0]             d_q_r;
    crate_state_e           state_r;
    crate_state_e           state_nxt;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   capture_s;
    logic                   match_s;
    logic                   push_s;
    logic                   space_s;
    logic                   drop_s;
    logic                   busy_r;
    logic                   overflow_r;
    logic [DROP_W-1:0]      drop_cnt_r;
    crate_rec_t             head_s;
    crate_rec_t             cap_rec_s;

    // Reset bridge: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    // Strobe synchroniser; resets high so no false falling edge follows reset.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sync_r      <= {SYNC_STAGES{1'b1}};
            strb_prev_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], strb_n};
            strb_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end
    assign strb_s = sync_r[SYNC_STAGES-1];
    assign fall_s = !strb_s && strb_prev_r;

    // Single register stage on the address and data buses.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            a_q_r <= 10'd0;
            d_q_r <= 8'd0;
        end else begin
            a_q_r <= A;
            d_q_r <= D;
        end
    end

    // Capture FSM next-state: one capture per strobe low period.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE - 1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (strb_s) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt = ST_CAPTURE;
                end else begin
                    cnt_nxt = cnt_r - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                capture_s = 1'b1;
                state_nxt = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (strb_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, settle counter and registered busy flag.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            busy_r  <= (state_nxt != ST_IDLE);
        end
    end

    assign match_s   = (a_q_r[9:7] == MODULE_ID);
    assign push_s    = capture_s && match_s;
    assign drop_s    = push_s && !space_s;
    assign cap_rec_s = pack_rec(a_q_r, d_q_r);

    // Sticky overflow and saturating drop counter; a drop beats a clear.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (clear_overflow) begin
                drop_cnt_r <= DROP_W'(1);
            end else if (drop_cnt_r != {DROP_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + DROP_W'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else if (clear_overflow) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    crate_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n_s),
        .push     (push_s),
        .push_rec (cap_rec_s),
        .ready    (rec_ready),
        .space    (space_s),
        .head     (head_s),
        .valid    (rec_valid),
        .level    (fifo_level)
    );

    assign rec_address = head_s.addr;
    assign rec_port    = head_s.port;
    assign rec_data    = head_s.data;
    assign overflow    = overflow_r;
    assign drop_count  = drop_cnt_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_crate_bus_capture.sv
// Directed bench for crate_bus_capture: stimulus pushes expected records into
// a queue, a negedge monitor pops and compares on every handshake.
module tb_crate_bus_capture;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] A;
    logic [7:0] D;
    logic       strb_n;
    logic       rec_valid;
    logic       rec_ready;
    logic [4:0] rec_address;
    logic [1:0] rec_port;
    logic [7:0] rec_data;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       clear_overflow;
    logic [7:0] drop_count;
    logic       busy;

    typedef struct {
        logic [4:0] a;
        logic [1:0] p;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    crate_bus_capture dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .A              (A),
        .D              (D),
        .strb_n         (strb_n),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_address    (rec_address),
        .rec_port       (rec_port),
        .rec_data       (rec_data),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [9:0] a, input logic [7:0] d);
        exp_t e;
        e.a = a[4:0];
        e.p = a[6:5];
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Full bus write: strobe low 12 cycles, then high long enough to return to IDLE.
    task automatic bus_write(input logic [9:0] a, input logic [7:0] d);
        A = a;
        D = d;
        strb_n = 1'b0;
        repeat (12) tick();
        strb_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic drain(input int n);
        rec_ready = 1'b1;
        repeat (n) tick();
        rec_ready = 1'b0;
    endtask

    // Scoreboard monitor: compare the head on every accepted handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_record: got data %0h expected none", rec_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_address", 32'(rec_address), 32'(e.a));
                check("sb_port", 32'(rec_port), 32'(e.p));
                check("sb_data", 32'(rec_data), 32'(e.d));
            end
        end
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a;
        reset_n        = 1'b0;
        A              = 10'd0;
        D              = 8'd0;
        strb_n         = 1'b1;
        rec_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (4) tick();
        check("rst_address", 32'(rec_address), 32'd0);
        check("rst_port", 32'(rec_port), 32'd0);
        check("rst_data", 32'(rec_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // Single write: valid on the 8th edge, one record for a long strobe.
        A = 10'b000_10_00101;
        D = 8'hA5;
        strb_n = 1'b0;
        repeat (7) tick();
        check("t1_valid_edge7", 32'(rec_valid), 32'd0);
        tick();
        check("t1_valid_edge8", 32'(rec_valid), 32'd1);
        check("t1_address", 32'(rec_address), 32'd5);
        check("t1_port", 32'(rec_port), 32'd2);
        check("t1_data", 32'(rec_data), 32'hA5);
        check("t1_level", 32'(fifo_level), 32'd1);
        push_exp(10'b000_10_00101, 8'hA5);
        repeat (4) tick();
        check("t1_level_held", 32'(fifo_level), 32'd1);
        check("t1_busy_held", 32'(busy), 32'd1);
        strb_n = 1'b1;
        repeat (6) tick();
        check("t1_level_after", 32'(fifo_level), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);
        drain(1);
        check("t1_level_drained", 32'(fifo_level), 32'd0);

        // Module filter: wrong valid code is ignored.
        A = {3'b101, 2'b01, 5'd3};
        D = 8'h3C;
        strb_n = 1'b0;
        repeat (10) tick();
        check("t2_busy_low", 32'(busy), 32'd1);
        repeat (2) tick();
        strb_n = 1'b1;
        repeat (6) tick();
        check("t2_level", 32'(fifo_level), 32'd0);
        check("t2_valid", 32'(rec_valid), 32'd0);
        check("t2_overflow", 32'(overflow), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);

        // Glitch: three-cycle strobe aborts in SETTLE.
        A = 10'b000_01_00111;
        D = 8'h5A;
        strb_n = 1'b0;
        repeat (3) tick();
        check("t3_busy_settle", 32'(busy), 32'd1);
        strb_n = 1'b1;
        repeat (10) tick();
        check("t3_level", 32'(fifo_level), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // Overflow: nine writes, the ninth is dropped.
        for (int i = 0; i < 9; i++) begin
            a = {3'b000, 2'(i), 5'(i + 1)};
            bus_write(a, 8'(i));
            if (i < 8) begin
                push_exp(a, 8'(i));
            end
        end
        check("t4_level", 32'(fifo_level), 32'd8);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_drop", 32'(drop_count), 32'd1);
        drain(8);
        check("t4_level_drained", 32'(fifo_level), 32'd0);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t4_clear_ovf", 32'(overflow), 32'd0);
        check("t4_clear_drop", 32'(drop_count), 32'd0);

        // Full with pop in the capture cycle.
        for (int i = 0; i < 8; i++) begin
            a = {3'b000, 2'b11, 5'(i)};
            bus_write(a, 8'(8'h10 + i));
            push_exp(a, 8'(8'h10 + i));
        end
        A = {3'b000, 2'b00, 5'h1F};
        D = 8'h99;
        push_exp({3'b000, 2'b00, 5'h1F}, 8'h99);
        strb_n = 1'b0;
        repeat (7) tick();
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check("t5_level_full", 32'(fifo_level), 32'd8);
        check("t5_no_overflow", 32'(overflow), 32'd0);
        check("t5_no_drop", 32'(drop_count), 32'd0);
        repeat (4) tick();
        strb_n = 1'b1;
        repeat (6) tick();
        bus_write(10'h001, 8'hE1);
        check("t5_drop1", 32'(drop_count), 32'd1);
        bus_write(10'h002, 8'hE2);
        check("t5_drop2", 32'(drop_count), 32'd2);
        A = 10'h003;
        D = 8'hE3;
        strb_n = 1'b0;
        repeat (7) tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t5_clear_drop_wins", 32'(drop_count), 32'd1);
        check("t5_clear_ovf_wins", 32'(overflow), 32'd1);
        repeat (4) tick();
        strb_n = 1'b1;
        repeat (6) tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t5_clear_drop", 32'(drop_count), 32'd0);
        check("t5_level_kept", 32'(fifo_level), 32'd8);
        drain(8);
        check("t5_level_drained", 32'(fifo_level), 32'd0);

        // Reset during SETTLE with three records stored.
        for (int i = 0; i < 3; i++) begin
            a = {3'b000, 2'b01, 5'(i + 4)};
            bus_write(a, 8'(8'hC0 + i));
            push_exp(a, 8'(8'hC0 + i));
        end
        check("t6_level3", 32'(fifo_level), 32'd3);
        A = 10'h010;
        D = 8'h77;
        strb_n = 1'b0;
        repeat (4) tick();
        check("t6_busy_settle", 32'(busy), 32'd1);
        reset_n = 1'b0;
        strb_n = 1'b1;
        #1;
        check("t6_valid", 32'(rec_valid), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_data", 32'(rec_data), 32'd0);
        check("t6_address", 32'(rec_address), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (15) tick();
        check("t6_level_after", 32'(fifo_level), 32'd0);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("t6_valid_after", 32'(rec_valid), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
